muldiv_unit: RTL and testbench

- Parametrised iterative RV32M/RV64M multiply/divide unit.
- Takes mul/div ops off the single-cycle ALU path and returns results through a start/completed handshake.
- Sits beside the ALU in the execute stage. The core holds the instruction while busy is high and writes back when completed pulses.
- Adds over the combinational ALU: configurable width, multi-cycle radix-2 datapath, busy/back-pressure, and RISC-V divide corner cases.

---
 rtl/muldiv_unit_if.sv | 22 ++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            completed;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2,
        input  busy, completed, result
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, completed, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// magnitude datapath with sign correction on the way out.
module muldiv_unit #(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input logic          clk,
    input logic          rstn,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpRem    = 3'd6;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;   // product, or {unused, quotient/dividend}
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;   // multiplicand or divisor magnitude
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   res_q, res_d;

    // Operand decode at the accepting edge
    logic            is_div, is_rem, s1_signed, s2_signed, rs1_neg, rs2_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] rs1_mag, rs2_mag, special_res;

    assign is_div    = bus.op[2];
    assign is_rem    = bus.op[2] & bus.op[1];
    assign s1_signed = (bus.op == OpMulh) || (bus.op == OpMulhsu) ||
                       (bus.op == OpDiv)  || (bus.op == OpRem);
    assign s2_signed = (bus.op == OpMulh) || (bus.op == OpDiv) || (bus.op == OpRem);
    assign rs1_neg   = s1_signed & bus.rs1[XLEN-1];
    assign rs2_neg   = s2_signed & bus.rs2[XLEN-1];
    assign rs1_mag   = rs1_neg ? -bus.rs1 : bus.rs1;
    assign rs2_mag   = rs2_neg ? -bus.rs2 : bus.rs2;
    assign div_zero  = (bus.rs2 == '0);
    assign div_ovf   = ((bus.op == OpDiv) || (bus.op == OpRem)) &&
                       (bus.rs1 == MinNeg) && (bus.rs2 == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? bus.rs1 : '1;
        end else if (div_ovf) begin
            special_res = is_rem ? '0 : MinNeg;
        end
    end

    // One datapath step per CALC cycle
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign div_shift = {rem_q, acc_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, dvs_q});
    // The true difference is below the divisor, so XLEN bits hold it exactly
    assign div_sub   = div_shift[XLEN-1:0] - dvs_q;

    // Sign correction and result selection for the FIN edge
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_sel;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -rem_q : rem_q;

    always_comb begin
        fin_sel = rem_fix;
        if (special_q) begin
            fin_sel = acc_q[XLEN-1:0];
        end else if (!op_q[2]) begin
            fin_sel = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            fin_sel = quo_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        special_d = special_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        res_d     = res_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    busy_d    = 1'b1;
                    special_d = 1'b0;
                    rem_d     = '0;
                    cnt_d     = CW'(XLEN - 1);
                    neg_d     = is_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
                    dvs_d     = is_div ? rs2_mag : rs1_mag;
                    if (is_div && (div_zero || div_ovf)) begin
                        special_d = 1'b1;
                        acc_d     = {{XLEN{1'b0}}, special_res};
                        state_d   = StFin;
                    end else if (is_div) begin
                        acc_d   = {{XLEN{1'b0}}, rs1_mag};
                        state_d = StCalc;
                    end else if (FAST_MUL) begin
                        acc_d   = {{XLEN{1'b0}}, rs1_mag} * {{XLEN{1'b0}}, rs2_mag};
                        state_d = StFin;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, rs2_mag};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (op_q[2]) begin
                    rem_d = div_ge ? div_sub : div_shift[XLEN-1:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                res_d   = fin_sel;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            op_q      <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_q     <= res_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.completed = done_q;
    assign bus.result    = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=64: the driver queues expected
// result, completion cycle and busy length; per-width monitors pop on each completed pulse.
module tb_muldiv_unit;
    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    typedef struct {
        logic [63:0] res;
        int unsigned due;
        int unsigned blen;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    int unsigned cyc  = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q32[$];
    exp_t        q64[$];
    int unsigned brun32 = 0;
    int unsigned brun64 = 0;

    muldiv_unit_if #(.XLEN(32)) b32 ();
    muldiv_unit_if #(.XLEN(64)) b64 ();

    muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut32 (.clk(clk), .rstn(rstn), .bus(b32));
    muldiv_unit #(.XLEN(64), .FAST_MUL(1'b0)) dut64 (.clk(clk), .rstn(rstn), .bus(b64));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b32.completed === 1'b1) begin
            if (q32.size() == 0) begin
                check("unexpected_completed32", 64'(b32.completed), 64'd0);
            end else begin
                e = q32.pop_front();
                check("result32", 64'(b32.result), e.res);
                check("latency32", 64'(cyc), 64'(e.due));
                check("busy_cycles32", 64'(brun32), 64'(e.blen));
                check("busy_at_done32", 64'(b32.busy), 64'd0);
            end
            brun32 = 0;
        end else if (b32.busy === 1'b1) begin
            brun32++;
        end else begin
            brun32 = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b64.completed === 1'b1) begin
            if (q64.size() == 0) begin
                check("unexpected_completed64", 64'(b64.completed), 64'd0);
            end else begin
                e = q64.pop_front();
                check("result64", b64.result, e.res);
                check("latency64", 64'(cyc), 64'(e.due));
                check("busy_cycles64", 64'(brun64), 64'(e.blen));
            end
            brun64 = 0;
        end else if (b64.busy === 1'b1) begin
            brun64++;
        end else begin
            brun64 = 0;
        end
    end

    // Called at a negedge; the next posedge is the accepting edge E0.
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input bit special, input bit hold);
        exp_t e;
        b32.op    = op;
        b32.rs1   = a;
        b32.rs2   = b;
        b32.start = 1'b1;
        e.res  = 64'(res);
        e.blen = special ? 1 : 33;
        e.due  = cyc + 1 + e.blen;
        q32.push_back(e);
        @(negedge clk);
        if (!hold) b32.start = 1'b0;
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (q32.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q32.size() != 0) begin
            errors++;
            $display("FAIL timeout32: %0d results still pending, expected 0", q32.size());
            q32.delete();
        end
        @(negedge clk);
    endtask

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input bit special);
        issue32(op, a, b, res, special, 1'b0);
        wait_idle32();
    endtask

    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input bit special);
        exp_t e;
        int   n = 0;
        b64.op    = op;
        b64.rs1   = a;
        b64.rs2   = b;
        b64.start = 1'b1;
        e.res  = res;
        e.blen = special ? 1 : 65;
        e.due  = cyc + 1 + e.blen;
        q64.push_back(e);
        @(negedge clk);
        b64.start = 1'b0;
        while (q64.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q64.size() != 0) begin
            errors++;
            $display("FAIL timeout64: %0d results still pending, expected 0", q64.size());
            q64.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        b32.start = 1'b0; b32.op = '0; b32.rs1 = '0; b32.rs2 = '0;
        b64.start = 1'b0; b64.op = '0; b64.rs1 = '0; b64.rs2 = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy32", 64'(b32.busy), 64'd0);
        check("reset_completed32", 64'(b32.completed), 64'd0);
        check("reset_result32", 64'(b32.result), 64'd0);
        check("reset_busy64", 64'(b64.busy), 64'd0);
        check("reset_completed64", 64'(b64.completed), 64'd0);
        check("reset_result64", b64.result, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Multiply, iterative
        run32(OpMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run32(OpMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run32(OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run32(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run32(OpMul,    32'h0000_1234, 32'd0,         32'd0,         1'b0);

        // Divide, iterative
        run32(OpDiv,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        run32(OpRem,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        run32(OpDivu, 32'd100,       32'd7,         32'd14,        1'b0);
        run32(OpRemu, 32'd100,       32'd7,         32'd2,         1'b0);
        run32(OpDiv,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run32(OpRem,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0);

        // Divide corner cases
        run32(OpDiv,  32'h0000_0055, 32'd0,         32'hFFFF_FFFF, 1'b1);
        run32(OpRemu, 32'h0000_1234, 32'd0,         32'h0000_1234, 1'b1);
        run32(OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run32(OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);

        // start pulsed while busy with different operands is ignored
        issue32(OpMul, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        b32.op = OpDiv; b32.rs1 = 32'd9; b32.rs2 = 32'd3; b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        wait_idle32();

        // start held through completion; operands scrambled while busy
        issue32(OpMulhu, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0, 1'b1);
        b32.op = OpRem; b32.rs1 = 32'd55; b32.rs2 = 32'd2;
        for (int i = 0; i < 100 && b32.completed !== 1'b1; i++) @(negedge clk);
        issue32(OpDivu, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0);
        wait_idle32();

        // Reset in CALC cycle 10 discards the op
        issue32(OpMul, 32'h0000_1111, 32'd3, 32'h0000_3333, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        q32.delete();
        @(negedge clk);
        rstn = 1'b1;
        check("midreset_busy32", 64'(b32.busy), 64'd0);
        check("midreset_completed32", 64'(b32.completed), 64'd0);
        check("midreset_result32", 64'(b32.result), 64'd0);
        repeat (40) @(negedge clk);
        run32(OpRem, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // XLEN=64
        run64(OpMul,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run64(OpMulh, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run64(OpDivu, 64'h0000_0001_0000_0000, 64'd3, 64'h0000_0000_5555_5555, 1'b0);
        run64(OpRemu, 64'h0000_0001_0000_0000, 64'd3, 64'd1,                  1'b0);
        run64(OpDiv,  64'd12345,               64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
